// File: rtl/issue_seq_pkg.sv
// Shared types and helpers for the issue sequencer and its bound walker.
package issue_seq_pkg;

  localparam int unsigned DIM_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSize,
    StStep,
    StBound,
    StWaitPe,
    StLaunch,
    StRun,
    StWb
  } state_e;

  function automatic logic [9:0] min_u10(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/issue_bound_calc.sv
// Coordinate walker: sizes one allocation, walks its end point into range, then registers
// the issue bounds and pulses done.
module issue_bound_calc
  import issue_seq_pkg::*;
#(
  parameter int unsigned ALLOC_SIZE = 64,
  parameter int unsigned DIM_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [8:0]       xs,
  input  logic [8:0]       ys,
  input  logic [8:0]       w,
  input  logic [15:0]      remaining,
  input  logic [3:0]       k,
  output logic             done,
  output logic [7:0]       n,
  output logic [9:0]       xe,
  output logic [8:0]       ye,
  output logic [DIM_W-1:0] x_min,
  output logic [DIM_W-1:0] x_max,
  output logic [DIM_W-1:0] x_start,
  output logic [DIM_W-1:0] x_end,
  output logic [DIM_W-1:0] y_min,
  output logic [DIM_W-1:0] y_max
);

  localparam logic [15:0] AllocSize = 16'(ALLOC_SIZE);

  state_e           phase_q, phase_d;
  logic             done_q, done_d;
  logic [7:0]       n_q, n_d;
  logic [9:0]       xe_q, xe_d;
  logic [8:0]       ye_q, ye_d;
  logic [DIM_W-1:0] x_max_q, x_max_d, x_start_q, x_start_d, x_end_q, x_end_d;
  logic [DIM_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic [15:0]      n16;
  logic [9:0]       w10, w_m1, k_m1, x_end_c, y_max_c;

  always_comb begin
    phase_d   = phase_q;
    done_d    = 1'b0;
    n_d       = n_q;
    xe_d      = xe_q;
    ye_d      = ye_q;
    x_max_d   = x_max_q;
    x_start_d = x_start_q;
    x_end_d   = x_end_q;
    y_min_d   = y_min_q;
    y_max_d   = y_max_q;
    n16       = (remaining < AllocSize) ? remaining : AllocSize;
    w10       = {1'b0, w};
    w_m1      = w10 - 10'd1;
    k_m1      = {6'd0, k} - 10'd1;
    // Kernel halo extends the last row/column; clamp to the padded plane edge.
    x_end_c   = min_u10(xe_q + k_m1, w_m1);
    y_max_c   = min_u10({1'b0, ye_q} + k_m1, w_m1);
    unique case (phase_q)
      StIdle: if (start) phase_d = StSize;
      StSize: begin
        n_d     = n16[7:0];
        xe_d    = {1'b0, xs} + {2'b0, n16[7:0]} - 10'd1;
        ye_d    = ys;
        phase_d = StStep;
      end
      StStep: begin
        if (xe_q >= w10) begin
          xe_d = xe_q - w10;
          ye_d = ye_q + 9'd1;
        end else begin
          phase_d = StBound;
        end
      end
      StBound: begin
        x_start_d = xs[DIM_W-1:0];
        y_min_d   = ys[DIM_W-1:0];
        x_end_d   = x_end_c[DIM_W-1:0];
        y_max_d   = y_max_c[DIM_W-1:0];
        x_max_d   = ({1'b0, ys} == y_max_c) ? x_end_c[DIM_W-1:0] : w_m1[DIM_W-1:0];
        done_d    = 1'b1;
        phase_d   = StIdle;
      end
      default: phase_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= StIdle;
      done_q    <= 1'b0;
      n_q       <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      x_max_q   <= '0;
      x_start_q <= '0;
      x_end_q   <= '0;
      y_min_q   <= '0;
      y_max_q   <= '0;
    end else begin
      phase_q   <= phase_d;
      done_q    <= done_d;
      n_q       <= n_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      x_max_q   <= x_max_d;
      x_start_q <= x_start_d;
      x_end_q   <= x_end_d;
      y_min_q   <= y_min_d;
      y_max_q   <= y_max_d;
    end
  end

  assign done    = done_q;
  assign n       = n_q;
  assign xe      = xe_q;
  assign ye      = ye_q;
  assign x_min   = '0;
  assign x_max   = x_max_q;
  assign x_start = x_start_q;
  assign x_end   = x_end_q;
  assign y_min   = y_min_q;
  assign y_max   = y_max_q;

endmodule

// File: rtl/issue_sequencer.sv
// Allocation scheduler for the issue-broadcast unit.
// Optional ISSUE_SEQ_PERF_EN adds a saturating stall_cycles counter (WAITPE + WB cycles).
module issue_sequencer
  import issue_seq_pkg::*;
#(
  parameter int unsigned ALLOC_SIZE = 64,
  parameter int unsigned DIM_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       image_dim,
  input  logic [1:0]       image_padding,
  input  logic [3:0]       kernel_dim,
  input  logic [8:0]       z_max,
  input  logic             pe_ready,
  input  logic             wb_done,
  output logic             iss_rst,
  output logic [DIM_W-1:0] iss_x_min,
  output logic [DIM_W-1:0] iss_x_max,
  output logic [DIM_W-1:0] iss_x_start,
  output logic [DIM_W-1:0] iss_x_end,
  output logic [DIM_W-1:0] iss_y_min,
  output logic [DIM_W-1:0] iss_y_max,
  output logic [8:0]       iss_z_max,
  input  logic             iss_done,
  output logic             alloc_valid,
  output logic [7:0]       alloc_index,
  output logic             busy,
`ifdef ISSUE_SEQ_PERF_EN
  output logic [31:0]      stall_cycles,
`endif
  output logic             layer_done
);

  state_e      state_q, state_d;
  logic [8:0]  w_q, w_d, xs_q, xs_d, ys_q, ys_d, z_q, z_d;
  logic [15:0] rem_q, rem_d;
  logic [3:0]  k_q, k_d;
  logic [7:0]  idx_q, idx_d;
  logic        iss_rst_q, iss_rst_d, alloc_valid_q, alloc_valid_d;
  logic        busy_q, busy_d, layer_done_q, layer_done_d, first_q, first_d;
  logic        calc_start, calc_done;
  logic [7:0]  calc_n;
  logic [9:0]  calc_xe, xs_next;
  logic [8:0]  calc_ye, w_new;
  logic [15:0] w16, l_new, rem_next;

  issue_bound_calc #(
    .ALLOC_SIZE(ALLOC_SIZE),
    .DIM_W     (DIM_W)
  ) u_calc (
    .clk      (clk),
    .rst      (rst),
    .start    (calc_start),
    .xs       (xs_q),
    .ys       (ys_q),
    .w        (w_q),
    .remaining(rem_q),
    .k        (k_q),
    .done     (calc_done),
    .n        (calc_n),
    .xe       (calc_xe),
    .ye       (calc_ye),
    .x_min    (iss_x_min),
    .x_max    (iss_x_max),
    .x_start  (iss_x_start),
    .x_end    (iss_x_end),
    .y_min    (iss_y_min),
    .y_max    (iss_y_max)
  );

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    rem_d         = rem_q;
    xs_d          = xs_q;
    ys_d          = ys_q;
    k_d           = k_q;
    z_d           = z_q;
    idx_d         = idx_q;
    iss_rst_d     = iss_rst_q;
    alloc_valid_d = alloc_valid_q;
    busy_d        = busy_q;
    layer_done_d  = 1'b0;
    first_d       = first_q;
    calc_start    = 1'b0;
    w_new         = {1'b0, image_dim} + {6'd0, image_padding, 1'b0};
    w16           = {7'd0, w_new};
    l_new         = (image_dim == 8'd0) ? 16'd0 : w16 * w16;
    rem_next      = rem_q - {8'd0, calc_n};
    xs_next       = calc_xe + 10'd1;
    unique case (state_q)
      StIdle: begin
        iss_rst_d = 1'b1;
        busy_d    = 1'b0;
        if (start) begin
          w_d   = w_new;
          rem_d = l_new;
          xs_d  = '0;
          ys_d  = '0;
          k_d   = kernel_dim;
          z_d   = z_max;
          idx_d = '0;
          if (l_new == 16'd0) begin
            layer_done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = StSize;
          end
        end
      end
      StSize: begin
        calc_start = 1'b1;
        state_d    = StStep;
      end
      StStep: if (calc_done) state_d = StWaitPe;
      StWaitPe: begin
        if (pe_ready) begin
          alloc_valid_d = 1'b1;
          state_d       = StLaunch;
        end
      end
      StLaunch: begin
        iss_rst_d = 1'b0;
        first_d   = 1'b1;
        state_d   = StRun;
      end
      StRun: begin
        // The issue unit's done is stale for one cycle after release.
        first_d = 1'b0;
        if (!first_q && iss_done) begin
          iss_rst_d = 1'b1;
          state_d   = StWb;
        end
      end
      StWb: begin
        if (wb_done) begin
          alloc_valid_d = 1'b0;
          rem_d         = rem_next;
          if (rem_next == 16'd0) begin
            layer_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = StIdle;
          end else begin
            if (xs_next == {1'b0, w_q}) begin
              xs_d = '0;
              ys_d = calc_ye + 9'd1;
            end else begin
              xs_d = xs_next[8:0];
              ys_d = calc_ye;
            end
            idx_d   = idx_q + 8'd1;
            state_d = StSize;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      w_q           <= '0;
      rem_q         <= '0;
      xs_q          <= '0;
      ys_q          <= '0;
      k_q           <= '0;
      z_q           <= '0;
      idx_q         <= '0;
      iss_rst_q     <= 1'b1;
      alloc_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
      first_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      w_q           <= w_d;
      rem_q         <= rem_d;
      xs_q          <= xs_d;
      ys_q          <= ys_d;
      k_q           <= k_d;
      z_q           <= z_d;
      idx_q         <= idx_d;
      iss_rst_q     <= iss_rst_d;
      alloc_valid_q <= alloc_valid_d;
      busy_q        <= busy_d;
      layer_done_q  <= layer_done_d;
      first_q       <= first_d;
    end
  end

`ifdef ISSUE_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == StIdle && start) begin
      stall_d = '0;
    end else if ((state_q == StWaitPe || state_q == StWb) && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

  assign iss_rst     = iss_rst_q;
  assign iss_z_max   = z_q;
  assign alloc_valid = alloc_valid_q;
  assign alloc_index = idx_q;
  assign busy        = busy_q;
  assign layer_done  = layer_done_q;

endmodule

// File: tb/tb_issue_sequencer.sv
// Directed bench for issue_sequencer with ALLOC_SIZE=16 on a 6x6 padded plane.
module tb_issue_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, pe_ready, wb_done, iss_done;
  logic [7:0] image_dim;
  logic [1:0] image_padding;
  logic [3:0] kernel_dim;
  logic [8:0] z_max, iss_z_max;
  logic       iss_rst, alloc_valid, busy, layer_done;
  logic [7:0] iss_x_min, iss_x_max, iss_x_start, iss_x_end, iss_y_min, iss_y_max, alloc_index;
`ifdef ISSUE_SEQ_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  issue_sequencer #(
    .ALLOC_SIZE(16),
    .DIM_W     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .image_dim    (image_dim),
    .image_padding(image_padding),
    .kernel_dim   (kernel_dim),
    .z_max        (z_max),
    .pe_ready     (pe_ready),
    .wb_done      (wb_done),
    .iss_rst      (iss_rst),
    .iss_x_min    (iss_x_min),
    .iss_x_max    (iss_x_max),
    .iss_x_start  (iss_x_start),
    .iss_x_end    (iss_x_end),
    .iss_y_min    (iss_y_min),
    .iss_y_max    (iss_y_max),
    .iss_z_max    (iss_z_max),
    .iss_done     (iss_done),
    .alloc_valid  (alloc_valid),
    .alloc_index  (alloc_index),
    .busy         (busy),
`ifdef ISSUE_SEQ_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .layer_done   (layer_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] dim, input logic [1:0] pad, input logic [3:0] k,
                          input logic [8:0] z);
    image_dim     = dim;
    image_padding = pad;
    kernel_dim    = k;
    z_max         = z;
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
  endtask

  // Follows one allocation from launch through writeback; iss_done is raised on the first
  // RUN cycle (stale) and held, and a stray wb_done is pulsed while running.
  task automatic run_alloc(input int idx, input int xs, input int ymin, input int xend,
                           input int ymax, input int xmax, input int wb_delay,
                           input bit last, input bit abort);
    int cnt = 0;
    while (alloc_valid !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check_val("alloc_valid_rise", alloc_valid, 1);
    check_val("alloc_index", alloc_index, idx);
    check_val("x_start", iss_x_start, xs);
    check_val("y_min", iss_y_min, ymin);
    check_val("x_end", iss_x_end, xend);
    check_val("y_max", iss_y_max, ymax);
    check_val("x_max", iss_x_max, xmax);
    check_val("x_min", iss_x_min, 0);
    check_val("rst_in_launch", iss_rst, 1);
    @(negedge clk);
    check_val("rst_released", iss_rst, 0);
    if (abort) return;
    iss_done = 1'b1;
    wb_done  = 1'b1;
    @(negedge clk);
    wb_done  = 1'b0;
    check_val("stale_done_ignored", iss_rst, 0);
    check_val("wb_in_run_ignored", alloc_valid, 1);
    @(negedge clk);
    iss_done = 1'b0;
    check_val("rst_after_done", iss_rst, 1);
    repeat (wb_delay - 1) @(negedge clk);
    wb_done = 1'b1;
    @(negedge clk);
    wb_done = 1'b0;
    check_val("alloc_valid_fall", alloc_valid, 0);
    check_val("layer_done", layer_done, 32'(last));
    check_val("busy_after_wb", busy, 32'(!last));
  endtask

  initial begin
    bit held;
    rst = 1'b1; start = 1'b0; pe_ready = 1'b0; wb_done = 1'b0; iss_done = 1'b0;
    image_dim = '0; image_padding = '0; kernel_dim = '0; z_max = '0;
    repeat (3) @(negedge clk);
    check_val("rst_iss_rst", iss_rst, 1);
    check_val("rst_alloc_valid", alloc_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_layer_done", layer_done, 0);
    check_val("rst_alloc_index", alloc_index, 0);
    check_val("rst_x_end", iss_x_end, 0);
    check_val("rst_y_max", iss_y_max, 0);
    rst = 1'b0;
    @(negedge clk);

    // Layer A: pe_ready held low well past bound computation.
    do_start(8'd4, 2'd1, 4'd3, 9'd300);
    check_val("busy_on_start", busy, 1);
    check_val("z_max_latched", iss_z_max, 300);
    held = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (iss_rst !== 1'b1 || alloc_valid !== 1'b0) held = 1'b0;
    end
    check_val("held_in_waitpe", held, 1);
    check_val("waitpe_x_end", iss_x_end, 5);
    pe_ready = 1'b1;
    @(negedge clk);
    check_val("launch_one_cycle", alloc_valid, 1);
    run_alloc(0, 0, 0, 5, 4, 5, 2, 1'b0, 1'b0);
    run_alloc(1, 4, 2, 3, 5, 5, 2, 1'b0, 1'b0);
    run_alloc(2, 2, 5, 5, 5, 5, 2, 1'b1, 1'b0);
    @(negedge clk);
    check_val("layer_done_pulse_end", layer_done, 0);

    // Layer B: abort with rst while alloc1 is running.
    do_start(8'd4, 2'd1, 4'd3, 9'd7);
    run_alloc(0, 0, 0, 5, 4, 5, 1, 1'b0, 1'b0);
    run_alloc(1, 4, 2, 3, 5, 5, 1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_val("abort_iss_rst", iss_rst, 1);
    check_val("abort_alloc_valid", alloc_valid, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_alloc_index", alloc_index, 0);
    check_val("abort_x_start", iss_x_start, 0);
    check_val("abort_y_min", iss_y_min, 0);
    @(negedge clk);
    rst = 1'b0;
    iss_done = 1'b1;
    wb_done  = 1'b1;
    @(negedge clk);
    iss_done = 1'b0;
    wb_done  = 1'b0;
    @(negedge clk);
    check_val("post_abort_busy", busy, 0);
    check_val("post_abort_layer_done", layer_done, 0);
    check_val("post_abort_iss_rst", iss_rst, 1);

    // Layer C: clean restart, writeback delayed 5 cycles each allocation.
    do_start(8'd4, 2'd1, 4'd3, 9'd12);
    run_alloc(0, 0, 0, 5, 4, 5, 5, 1'b0, 1'b0);
    run_alloc(1, 4, 2, 3, 5, 5, 5, 1'b0, 1'b0);
    run_alloc(2, 2, 5, 5, 5, 5, 5, 1'b1, 1'b0);
`ifdef ISSUE_SEQ_PERF_EN
    check_val("stall_cycles", stall_cycles, 18);
`endif

    // Layer D: empty image completes without ever releasing the issue unit.
    do_start(8'd0, 2'd1, 4'd3, 9'd5);
    check_val("empty_layer_done", layer_done, 1);
    check_val("empty_busy", busy, 0);
    held = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (iss_rst !== 1'b1 || alloc_valid !== 1'b0) held = 1'b0;
    end
    check_val("empty_no_launch", held, 1);
    check_val("empty_done_cleared", layer_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
